// File: rtl/levenshtein_search_engine.sv
// Myers bit-parallel Levenshtein search over a byte dictionary fetched by a Wishbone master,
// configured via an 8-bit Wishbone slave. Optional macro: LEVENSHTEIN_MATCH_COUNT_EN.
module levenshtein_search_engine #(
    parameter int MASTER_ADDR_WIDTH = 24,
    parameter int SLAVE_ADDR_WIDTH  = 24,
    parameter int BITVECTOR_WIDTH   = 16,
    parameter int DISTANCE_WIDTH    = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output logic                         wbm_cyc_o,
    output logic                         wbm_stb_o,
    output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
    input  logic                         wbm_ack_i,
    input  logic                         wbm_err_i,
    input  logic                         wbm_rty_i,
    input  logic [7:0]                   wbm_dat_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
    input  logic [7:0]                   wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic                         wbs_err_o,
    output logic                         wbs_rty_o,
    output logic [7:0]                   wbs_dat_o,
    output logic                         irq_o
);
    localparam int BW = BITVECTOR_WIDTH;
    localparam int DW = DISTANCE_WIDTH;
    localparam int NB = BW / 8;
    localparam int AW = MASTER_ADDR_WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_READ_DICT, S_READ_VEC, S_STEP} state_t;

    state_t          r_state;
    logic            r_enabled, r_done, r_error, r_cyc, r_ack;
    logic [DW-1:0]   r_length, r_threshold, r_d, r_best_dist;
    logic [BW-1:0]   r_mask, r_init_vp, r_vp, r_vn, r_pm;
    logic [15:0]     r_idx, r_best_idx;
    logic [AW-1:0]   r_dict_addr;
    logic [7:0]      r_c;
    logic [1:0]      r_k;
`ifdef LEVENSHTEIN_MATCH_COUNT_EN
    logic [DW-1:0]   r_match_count;
`endif

    logic            w_req, w_wr, w_ctrl_wr, w_fault, w_unused;
    logic [3:0]      w_reg;
    logic [7:0]      w_match_rd, w_rd;
    logic [31:0]     w_mask32, w_vp32;
    logic [AW-1:0]   w_vec_off;
    logic [BW-1:0]   w_d0, w_hp, w_hn, w_hp_sh, w_vp_next, w_vn_next;

    assign w_reg     = wbs_adr_i[3:0];
    assign w_unused  = ^wbs_adr_i[SLAVE_ADDR_WIDTH-1:4];
    assign w_req     = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr      = w_req & wbs_we_i;
    assign w_ctrl_wr = w_wr & (w_reg == 4'd0);
    assign w_fault   = r_cyc & (wbm_err_i | wbm_rty_i);

    // Myers column update, evaluated from the state held during S_STEP
    assign w_d0      = (((r_pm & r_vp) + r_vp) ^ r_vp) | r_pm | r_vn;
    assign w_hp      = r_vn | ~(w_d0 | r_vp);
    assign w_hn      = w_d0 & r_vp;
    assign w_hp_sh   = (w_hp << 1) | BW'(1);
    assign w_vp_next = (w_hn << 1) | ~(w_d0 | w_hp_sh);
    assign w_vn_next = w_d0 & w_hp_sh;

    assign w_vec_off = AW'(r_c) * AW'(NB) + AW'(r_k);
    assign wbm_adr_o = (r_state == S_READ_DICT) ? {1'b1, r_dict_addr} : {1'b0, w_vec_off};
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbs_ack_o = r_ack;
    assign wbs_err_o = 1'b0;
    assign wbs_rty_o = 1'b0;
    assign irq_o     = r_done | r_error;

`ifdef LEVENSHTEIN_MATCH_COUNT_EN
    assign w_match_rd = 8'(r_match_count);
`else
    assign w_match_rd = 8'h00;
`endif

    assign w_mask32 = 32'(r_mask);
    assign w_vp32   = 32'(r_init_vp);

    always_comb begin
        w_rd = 8'h00;
        case (w_reg)
            4'd0:  w_rd = {5'b0, r_error, r_done, r_enabled};
            4'd1:  w_rd = 8'(r_length);
            4'd2:  w_rd = 8'(r_threshold);
            4'd3:  w_rd = w_match_rd;
            4'd4:  w_rd = w_mask32[31:24];
            4'd5:  w_rd = w_mask32[23:16];
            4'd6:  w_rd = w_mask32[15:8];
            4'd7:  w_rd = w_mask32[7:0];
            4'd8:  w_rd = w_vp32[31:24];
            4'd9:  w_rd = w_vp32[23:16];
            4'd10: w_rd = w_vp32[15:8];
            4'd11: w_rd = w_vp32[7:0];
            4'd12: w_rd = 8'(r_best_dist);
            4'd13: w_rd = r_best_idx[15:8];
            4'd14: w_rd = r_best_idx[7:0];
            default: w_rd = 8'h00;
        endcase
    end
    assign wbs_dat_o = w_rd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_enabled   <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cyc       <= 1'b0;
            r_ack       <= 1'b0;
            r_length    <= '0;
            r_threshold <= '0;
            r_mask      <= '0;
            r_init_vp   <= '0;
            r_d         <= '0;
            r_vp        <= '0;
            r_vn        <= '0;
            r_pm        <= '0;
            r_best_dist <= '1;
            r_idx       <= '0;
            r_best_idx  <= '0;
            r_dict_addr <= '0;
            r_c         <= '0;
            r_k         <= '0;
`ifdef LEVENSHTEIN_MATCH_COUNT_EN
            r_match_count <= '0;
`endif
        end else begin
            r_ack <= w_req;
            if (w_wr) begin
                case (w_reg)
                    4'd1:    r_length    <= DW'(wbs_dat_i);
                    4'd2:    r_threshold <= DW'(wbs_dat_i);
                    default: ;
                endcase
                // byte lanes wider than the bitvector simply have no matching lane
                for (int b = 0; b < NB; b++) begin
                    if (w_reg == 4'(7 - b))  r_mask[b*8 +: 8]    <= wbs_dat_i;
                    if (w_reg == 4'(11 - b)) r_init_vp[b*8 +: 8] <= wbs_dat_i;
                end
            end

            if (w_ctrl_wr) begin
                r_enabled   <= wbs_dat_i[0];
                r_done      <= 1'b0;
                r_error     <= 1'b0;
                r_idx       <= '0;
                r_best_idx  <= '0;
                r_best_dist <= '1;
                r_d         <= r_length;
                r_vp        <= r_init_vp;
                r_vn        <= '0;
                r_dict_addr <= '0;
                r_k         <= '0;
                r_cyc       <= 1'b0;
                r_state     <= wbs_dat_i[0] ? S_READ_DICT : S_IDLE;
`ifdef LEVENSHTEIN_MATCH_COUNT_EN
                r_match_count <= '0;
`endif
            end else if (w_fault) begin
                r_cyc     <= 1'b0;
                r_enabled <= 1'b0;
                r_error   <= 1'b1;
                r_state   <= S_IDLE;
            end else begin
                case (r_state)
                    S_READ_DICT: begin
                        if (!r_cyc) begin
                            r_cyc <= 1'b1;
                        end else if (wbm_ack_i) begin
                            r_cyc       <= 1'b0;
                            r_dict_addr <= r_dict_addr + AW'(1);
                            if (wbm_dat_i == 8'hFE) begin
                                if (r_d <= r_threshold && r_d < r_best_dist) begin
                                    r_best_dist <= r_d;
                                    r_best_idx  <= r_idx;
                                end
`ifdef LEVENSHTEIN_MATCH_COUNT_EN
                                if (r_d <= r_threshold && r_match_count != '1)
                                    r_match_count <= r_match_count + DW'(1);
`endif
                                r_idx <= r_idx + 16'd1;
                                r_d   <= r_length;
                                r_vp  <= r_init_vp;
                                r_vn  <= '0;
                            end else if (wbm_dat_i == 8'hFF) begin
                                r_enabled <= 1'b0;
                                r_done    <= 1'b1;
                                r_state   <= S_IDLE;
                            end else begin
                                r_c     <= wbm_dat_i;
                                r_k     <= '0;
                                r_state <= S_READ_VEC;
                            end
                        end
                    end
                    S_READ_VEC: begin
                        if (!r_cyc) begin
                            r_cyc <= 1'b1;
                        end else if (wbm_ack_i) begin
                            r_pm <= (r_pm << 8) | BW'(wbm_dat_i);
                            if (r_k == 2'(NB - 1)) begin
                                r_cyc   <= 1'b0;
                                r_state <= S_STEP;
                            end else begin
                                r_k <= r_k + 2'd1;
                            end
                        end
                    end
                    S_STEP: begin
                        r_vp <= w_vp_next;
                        r_vn <= w_vn_next;
                        if ((w_hp & r_mask) != '0)
                            r_d <= r_d + DW'(1);
                        else if ((w_hn & r_mask) != '0)
                            r_d <= r_d - DW'(1);
                        r_state <= S_READ_DICT;
                    end
                    default: r_cyc <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: doc/levenshtein_search_engine.md
LEVENSHTEIN_SEARCH_ENGINE -- requirements
Module: levenshtein_search_engine

Interface
REQ-001 SHALL have parameter MASTER_ADDR_WIDTH, default 24, width of dictionary/vector read address.
REQ-002 SHALL have parameter SLAVE_ADDR_WIDTH, default 24, width of register slave address; only bits [3:0] are decoded.
REQ-003 SHALL have parameter BITVECTOR_WIDTH, default 16, Myers bitvector width; legal values 8, 16, 24, 32; NB = BITVECTOR_WIDTH/8.
REQ-004 SHALL have parameter DISTANCE_WIDTH, default 8, width of distance, threshold and match counter.
REQ-005 One clock, asynchronous active-low reset: clk_i (in, 1, clock) and rst_ni (in, 1, async reset, active low).
REQ-006 Ports: wbm_cyc_o/wbm_stb_o out 1 (master cycle/strobe, tied together); wbm_adr_o out MASTER_ADDR_WIDTH; wbm_ack_i, wbm_err_i, wbm_rty_i in 1; wbm_dat_i in 8.
REQ-007 Ports: wbs_cyc_i, wbs_stb_i, wbs_we_i in 1; wbs_adr_i in SLAVE_ADDR_WIDTH; wbs_dat_i in 8; wbs_ack_o out 1; wbs_err_o, wbs_rty_o out 1 (tied 0); wbs_dat_o out 8.
REQ-008 irq_o out 1: high while DONE or ERROR status bit is set.

Function
REQ-009 Registers (adr[3:0]): 0 CTRL (w bit0 enable; r {5'b0, error, done, enabled}), 1 LENGTH, 2 THRESHOLD, 3 MATCH_COUNT (ro), 4-7 MASK bytes [31:24]..[7:0], 8-11 INITIAL_VP bytes [31:24]..[7:0], 12 DISTANCE (ro), 13 IDX_HI (ro), 14 IDX_LO (ro), 15 reads 0.
REQ-010 Mask/initial_vp bytes beyond BITVECTOR_WIDTH SHALL read 0 and ignore writes; LENGTH/THRESHOLD truncated or zero-extended to DISTANCE_WIDTH.
REQ-011 Slave: a request with cyc&stb&!wbs_ack_o SHALL be acked exactly one cycle later for one cycle; wbs_dat_o is combinational from adr.
REQ-012 Writing CTRL SHALL set enabled=dat[0], clear done/error/idx/match_count, set best_distance=all-ones, best_idx=0, d=LENGTH, vp=INITIAL_VP, vn=0, dict address=0, state=READ_DICT.
REQ-013 States: IDLE (enabled=0), READ_DICT, READ_VEC, STEP; any master read raises cyc the cycle after entry and holds it until ack/err/rty.
REQ-014 READ_DICT address {1'b1, dict_addr}; on ack dict_addr increments; byte 0xFE = word end, 0xFF = list end, else char c -> READ_VEC with byte counter k=0.
REQ-015 On 0xFE: if d<=THRESHOLD and d<best_distance then best_distance=d, best_idx=idx; idx+1; d=LENGTH, vp=INITIAL_VP, vn=0; stay READ_DICT.
REQ-016 On 0xFF: enabled=0, done=1, cyc dropped, -> IDLE.
REQ-017 READ_VEC reads address {1'b0, c*NB+k} (zero-extended), bytes MSB first into pm; cyc held across NB consecutive acks; after k=NB-1 -> STEP.
REQ-018 STEP (one cycle): d0=(((pm&vp)+vp)^vp)|pm|vn; hp=vn|~(d0|vp); hn=d0&vp; d+1 if (hp&mask)!=0, else d-1 if (hn&mask)!=0; vp=(hn<<1)|~(d0|((hp<<1)|1)); vn=d0&((hp<<1)|1); -> READ_DICT.
REQ-019 Arithmetic modulo 2^BITVECTOR_WIDTH / 2^DISTANCE_WIDTH; idx is 16 bits and wraps.
REQ-020 err or rty on master SHALL drop cyc, clear enabled, set error, -> IDLE; best results retained.
REQ-021 Writing CTRL with bit0=0 mid-search SHALL abort: cyc dropped next cycle, no done set.
REQ-022 Slave write and engine update of the same register in one cycle: slave write wins.

Reset
REQ-023 rst_ni low SHALL asynchronously clear: enabled, done, error, cyc, wbs_ack_o, irq_o, all config registers, idx, best_idx, match_count, dict_addr, vp, vn, d to 0; best_distance to all-ones; state IDLE.

Configuration
REQ-024 Macro LEVENSHTEIN_MATCH_COUNT_EN defined: on each 0xFE with d<=THRESHOLD, match_count increments, saturating at all-ones; register 3 returns it. Undefined: counter absent, register 3 reads 0.

Verification
REQ-025 LENGTH=3, mask=0x0004, vp=0x0007, dict "cat",FE,FF, vectors for "cat" -> done=1, DISTANCE=0, IDX=0, irq_o=1.
REQ-026 Dict "cut",FE,"cat",FE,FF, THRESHOLD=2 -> DISTANCE=0, IDX=1; with MATCH_COUNT_EN MATCH_COUNT=2.
REQ-027 THRESHOLD=0, dict "dog",FE,FF -> DISTANCE=0xFF, IDX=0, done=1.
REQ-028 BITVECTOR_WIDTH=32: each char produces exactly 4 vector reads at c*4..c*4+3; result matches REQ-025.
REQ-029 wbm_err_i on third read -> CTRL reads 0x04, cyc low next cycle, irq_o=1.
REQ-030 rst_ni asserted mid-READ_VEC -> all outputs reset asynchronously, cyc low before next clock edge.
